// File: rtl/rtc_tick_gen.sv
// Fractional RTC square-wave divider feeding the CLINT rtc input, with a one-entry config shadow.
// Define RTC_TICK_GEN_CNT_EN to add a 32-bit rising-edge counter output (tick_cnt_o).
module rtc_tick_gen #(
  parameter int unsigned IntWidth  = 16,
  parameter int unsigned FracWidth = 8,
  parameter logic [IntWidth-1:0]  RstDivInt  = 16'd763,
  parameter logic [FracWidth-1:0] RstDivFrac = 8'd0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [IntWidth-1:0]  div_int_i,
  input  logic [FracWidth-1:0] div_frac_i,
  output logic                 rtc_o,
  output logic                 busy_o
`ifdef RTC_TICK_GEN_CNT_EN
  ,
  output logic [31:0]          tick_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, RUN_LO, RUN_HI} state_t;

  state_t               state;
  logic [IntWidth-1:0]  cnt;
  logic [FracWidth-1:0] acc;
  logic                 pending;
  logic                 rtc;
  logic [IntWidth-1:0]  act_int, pend_int;
  logic [FracWidth-1:0] act_frac, pend_frac;

  logic [IntWidth-1:0]  sel_int, eff_int, eff_m1, reload;
  logic [FracWidth-1:0] sel_frac;
  logic [FracWidth:0]   sum;
  logic                 boundary, apply, cfg_take;

  // A pending config already governs the reload at the boundary where it is applied.
  always_comb begin
    sel_int  = pending ? pend_int  : act_int;
    sel_frac = pending ? pend_frac : act_frac;
    eff_int  = (sel_int < IntWidth'(2)) ? IntWidth'(2) : sel_int;
    eff_m1   = eff_int - IntWidth'(1);
    sum      = {1'b0, acc} + {1'b0, sel_frac};
    reload   = eff_m1 + {{(IntWidth-1){1'b0}}, sum[FracWidth]};
    boundary = (state != IDLE) && en_i && (cnt == '0);
    apply    = pending && ((state == IDLE) || boundary);
    cfg_take = cfg_valid_i && !pending;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      pending   <= 1'b0;
      rtc       <= 1'b0;
      act_int   <= RstDivInt;
      act_frac  <= RstDivFrac;
      pend_int  <= '0;
      pend_frac <= '0;
    end else begin
      if (cfg_take) begin
        pend_int  <= div_int_i;
        pend_frac <= div_frac_i;
        pending   <= 1'b1;
      end
      if (apply) begin
        act_int  <= pend_int;
        act_frac <= pend_frac;
        pending  <= 1'b0;
      end
      case (state)
        IDLE: begin
          rtc <= 1'b0;
          acc <= '0;
          if (en_i) begin
            state <= RUN_LO;
            cnt   <= eff_m1;
          end
        end
        RUN_LO, RUN_HI: begin
          if (!en_i) begin
            state <= IDLE;
            rtc   <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
          end else if (cnt == '0) begin
            state <= (state == RUN_LO) ? RUN_HI : RUN_LO;
            rtc   <= (state == RUN_LO);
            acc   <= sum[FracWidth-1:0];
            cnt   <= reload;
          end else begin
            cnt <= cnt - IntWidth'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rtc_o       = rtc;
  assign busy_o      = (state != IDLE);
  assign cfg_ready_o = !pending;

`ifdef RTC_TICK_GEN_CNT_EN
  logic [31:0] tick_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      tick_cnt <= '0;
    else if (state == IDLE)
      tick_cnt <= '0;
    else if (state == RUN_LO && boundary)
      tick_cnt <= tick_cnt + 32'd1;
  end

  assign tick_cnt_o = tick_cnt;
`endif

endmodule

// File: tb/tb_rtc_tick_gen.sv
// Bench for rtc_tick_gen: level-length scoreboard plus directed handshake, enable and reset sequences.
module tb_rtc_tick_gen;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic [15:0] div_int_i;
  logic [7:0]  div_frac_i;
  logic        rtc_o;
  logic        busy_o;
`ifdef RTC_TICK_GEN_CNT_EN
  logic [31:0] tick_cnt_o;
`endif

  rtc_tick_gen dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .div_int_i(div_int_i), .div_frac_i(div_frac_i),
    .rtc_o(rtc_o), .busy_o(busy_o)
`ifdef RTC_TICK_GEN_CNT_EN
    , .tick_cnt_o(tick_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int di;
    int df;
    int rise;
    int lv[6];
  } vec_t;

  vec_t tv[$];
  int   exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: measures every rtc_o level while busy and compares against queued lengths.
  logic prev_rtc = 1'b0, prev_busy = 1'b0;
  int   len = 0;
  always @(posedge clk_i) begin
    #1;
    if (!rst_ni) begin
      prev_rtc = 1'b0; prev_busy = 1'b0; len = 0;
    end else begin
      if (busy_o) begin
        if (!prev_busy) len = 0;
        else begin
          len++;
          if (rtc_o != prev_rtc) begin
            if (exp_q.size() > 0) check("level_len", len, exp_q.pop_front());
            len = 0;
          end
        end
      end
      prev_rtc  = rtc_o;
      prev_busy = busy_o;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (exp_q.size() > 0 && n < bound) begin tick(); n++; end
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic set_cfg(input int di, input int df);
    logic hs;
    cfg_valid_i = 1'b1; div_int_i = 16'(di); div_frac_i = 8'(df);
    for (int i = 0; i < 20; i++) begin
      hs = cfg_ready_o;
      tick();
      if (hs) break;
    end
    cfg_valid_i = 1'b0;
    tick();
  endtask

  task automatic wait_rise(input int bound, output int n);
    n = 0;
    while (!rtc_o && n < bound) begin tick(); n++; end
    if (!rtc_o) n = -1;
  endtask

  task automatic add(input int di, input int df, input int rise,
                     input int l0, input int l1, input int l2,
                     input int l3, input int l4, input int l5);
    vec_t r;
    r.di = di; r.df = df; r.rise = rise;
    r.lv[0] = l0; r.lv[1] = l1; r.lv[2] = l2;
    r.lv[3] = l3; r.lv[4] = l4; r.lv[5] = l5;
    tv.push_back(r);
  endtask

  initial begin
    int n, hs1, hs2, bnd, rises;
    logic hs, pr;

    add(4, 8'h00, 5, 4, 4, 4, 4, 4, 4);
    add(3, 8'h80, 4, 3, 3, 4, 3, 4, 3);
    add(0, 8'h00, 3, 2, 2, 2, 2, 2, 2);
    add(1, 8'h00, 3, 2, 2, 2, 2, 2, 2);
    add(2, 8'h40, 3, 2, 2, 2, 2, 3, 2);
    add(5, 8'hFF, 6, 5, 5, 6, 6, 6, 6);

    rst_ni = 1'b0; en_i = 1'b0; cfg_valid_i = 1'b0;
    div_int_i = '0; div_frac_i = '0;
    #12;
    check("rst_rtc", int'(rtc_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_ready", int'(cfg_ready_o), 1);
    @(negedge clk_i); rst_ni = 1'b1;
    tick();

    foreach (tv[k]) begin
      set_cfg(tv[k].di, tv[k].df);
      foreach (tv[k].lv[j]) exp_q.push_back(tv[k].lv[j]);
      en_i = 1'b1;
      tick();
      check("busy_on", int'(busy_o), 1);
      wait_rise(100, n);
      check("first_rise", n + 1, tv[k].rise);
      drain(200);
      en_i = 1'b0;
      tick(); tick();
    end

    // Average period for 3 + 0x80: 100 periods after the first rise span 700 cycles.
    set_cfg(3, 8'h80);
    en_i = 1'b1;
    wait_rise(100, n);
    rises = 0; n = 0; pr = rtc_o;
    while (rises < 100 && n < 2000) begin
      tick(); n++;
      if (rtc_o && !pr) rises++;
      pr = rtc_o;
    end
    check("avg_700", n, 700);
    en_i = 1'b0; tick(); tick();

    // Back-to-back configs 10 then 6 while running at 4.
    set_cfg(4, 0);
    exp_q.push_back(4); exp_q.push_back(4);
    en_i = 1'b1;
    drain(100);
    exp_q.push_back(4); exp_q.push_back(10); exp_q.push_back(6); exp_q.push_back(6);
    cfg_valid_i = 1'b1; div_int_i = 16'd10; div_frac_i = 8'd0;
    hs1 = -1; hs2 = -1; bnd = -1; pr = rtc_o;
    for (int i = 1; i <= 30; i++) begin
      hs = cfg_valid_i && cfg_ready_o;
      tick();
      if (hs) begin
        if (hs1 < 0) begin
          hs1 = i;
          check("b2b_ready_low", int'(cfg_ready_o), 0);
          div_int_i = 16'd6;
        end else begin
          hs2 = i;
          cfg_valid_i = 1'b0;
        end
      end
      if (rtc_o != pr && hs1 >= 0 && bnd < 0) bnd = i;
      pr = rtc_o;
    end
    check("b2b_hs1", hs1, 1);
    check("b2b_bnd", bnd, 4);
    check("b2b_hs2", hs2, bnd + 1);
    drain(100);
    en_i = 1'b0; tick(); tick();

    // Drop en_i mid RUN_HI with acc=0x80, then re-enable: acc must restart at 0.
    set_cfg(3, 8'h80);
    exp_q.push_back(3);
    en_i = 1'b1;
    drain(50);
    tick();
    en_i = 1'b0;
    tick();
    check("dis_rtc", int'(rtc_o), 0);
    check("dis_busy", int'(busy_o), 0);
    exp_q.push_back(3); exp_q.push_back(3); exp_q.push_back(4);
    en_i = 1'b1;
    drain(50);
    en_i = 1'b0; tick(); tick();

`ifdef RTC_TICK_GEN_CNT_EN
    set_cfg(2, 0);
    en_i = 1'b1;
    rises = 0; n = 0; pr = rtc_o;
    while (rises < 100 && n < 2000) begin
      tick(); n++;
      if (rtc_o && !pr) rises++;
      pr = rtc_o;
    end
    check("tick_cnt_100", int'(tick_cnt_o), 100);
    en_i = 1'b0; tick(); tick();
    check("tick_cnt_clr", int'(tick_cnt_o), 0);
`endif

    // Async reset mid-run with a pending config.
    set_cfg(4, 0);
    en_i = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    cfg_valid_i = 1'b1; div_int_i = 16'd9;
    tick();
    cfg_valid_i = 1'b0;
    check("pend_ready", int'(cfg_ready_o), 0);
    #1 rst_ni = 1'b0;
    #1;
    check("mid_rst_rtc", int'(rtc_o), 0);
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_ready", int'(cfg_ready_o), 1);
    en_i = 1'b0;
    exp_q.delete();
    @(negedge clk_i); rst_ni = 1'b1;
    tick();
    exp_q.push_back(763); exp_q.push_back(763);
    en_i = 1'b1;
    wait_rise(2000, n);
    check("rst_div_rise", n, 764);
    drain(2000);
    en_i = 1'b0; tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
